// File: rtl/exp5_pkg.sv
// Shared definitions for the memory game: FSM state codes, stored play sequence
// and the last sequence address.
package exp5_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTOU = 4'hA,
      FIM_ERROU   = 4'hE
   } estado_t;

   localparam logic [3:0] LAST_ADDR = 4'hF;

   localparam logic [3:0] ROM_DATA [16] = '{
      4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
      4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
   };

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module hexa7seg (
   input  logic [3:0] hexa,
   output logic [6:0] display
);

   always_comb begin
      display = 7'b1111111;
      case (hexa)
         4'h0: display = 7'b1000000;
         4'h1: display = 7'b1111001;
         4'h2: display = 7'b0100100;
         4'h3: display = 7'b0110000;
         4'h4: display = 7'b0011001;
         4'h5: display = 7'b0010010;
         4'h6: display = 7'b0000010;
         4'h7: display = 7'b1111000;
         4'h8: display = 7'b0000000;
         4'h9: display = 7'b0010000;
         4'hA: display = 7'b0001000;
         4'hB: display = 7'b0000011;
         4'hC: display = 7'b1000110;
         4'hD: display = 7'b0100001;
         4'hE: display = 7'b0000110;
         4'hF: display = 7'b0001110;
         default: display = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/circuito_exp5.sv
// Memory game top: control FSM plus datapath matching 16 stored plays.
// Define DB_HEX_EN to drive the four 7-segment debug displays; otherwise they are blank.
module circuito_exp5 (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] chaves,
   output logic       acertou,
   output logic       errou,
   output logic       pronto,
   output logic [3:0] leds,
   output logic       db_igual,
   output logic [6:0] db_contagem,
   output logic [6:0] db_memoria,
   output logic [6:0] db_estado,
   output logic [6:0] db_jogadafeita,
   output logic       db_clock,
   output logic       db_iniciar,
   output logic       db_tem_jogada
);
   import exp5_pkg::*;

   estado_t    estado_q, estado_d;
   logic [3:0] cont_q, cont_d;
   logic [3:0] jogada_q, jogada_d;
   logic       prev_q, prev_d;

   logic       any_chave;
   logic       tem_jogada;
   logic [3:0] rom_data;
   logic       igual;
   logic [3:0] estado_cod;

   // A play is registered once per press: only the 0->1 transition of |chaves counts.
   assign any_chave  = |chaves;
   assign prev_d     = any_chave;
   assign tem_jogada = any_chave & ~prev_q;
   assign rom_data   = ROM_DATA[cont_q];
   assign igual      = (jogada_q == rom_data);
   assign estado_cod = estado_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIAL;
         cont_q   <= 4'd0;
         jogada_q <= 4'd0;
         prev_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cont_q   <= cont_d;
         jogada_q <= jogada_d;
         prev_q   <= prev_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      jogada_d = jogada_q;
      case (estado_q)
         INICIAL:     if (iniciar) estado_d = PREPARACAO;
         PREPARACAO: begin
            cont_d   = 4'd0;
            jogada_d = 4'd0;
            estado_d = ESPERA;
         end
         ESPERA:      if (tem_jogada) estado_d = REGISTRA;
         REGISTRA: begin
            jogada_d = chaves;
            estado_d = COMPARACAO;
         end
         COMPARACAO: begin
            if (!igual)                   estado_d = FIM_ERROU;
            else if (cont_q == LAST_ADDR) estado_d = FIM_ACERTOU;
            else                          estado_d = PROXIMO;
         end
         PROXIMO: begin
            cont_d   = cont_q + 4'd1;
            estado_d = ESPERA;
         end
         FIM_ACERTOU, FIM_ERROU: if (iniciar) estado_d = PREPARACAO;
         default:     estado_d = INICIAL;
      endcase
   end

   assign acertou       = (estado_q == FIM_ACERTOU);
   assign errou         = (estado_q == FIM_ERROU);
   assign pronto        = acertou | errou;
   assign leds          = chaves;
   assign db_igual      = igual;
   assign db_clock      = clock;
   assign db_iniciar    = iniciar;
   assign db_tem_jogada = tem_jogada;

`ifdef DB_HEX_EN
   hexa7seg u_hex_contagem (.hexa(cont_q),     .display(db_contagem));
   hexa7seg u_hex_memoria  (.hexa(rom_data),   .display(db_memoria));
   hexa7seg u_hex_estado   (.hexa(estado_cod), .display(db_estado));
   hexa7seg u_hex_jogada   (.hexa(jogada_q),   .display(db_jogadafeita));
`else
   assign db_contagem    = 7'b1111111;
   assign db_memoria     = 7'b1111111;
   assign db_estado      = 7'b1111111;
   assign db_jogadafeita = 7'b1111111;
`endif

endmodule

// File: tb/tb_circuito_exp5.sv
// Randomized self-checking bench for circuito_exp5 against a game-level model
// (position in sequence, outcome, last registered play).
module tb_circuito_exp5;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic [3:0] chaves = 4'd0;
   logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
   logic [3:0] leds;
   logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

   int n_checks = 0;
   int n_fail   = 0;

   circuito_exp5 dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
      .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
      .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
      .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
   );

   // clock / reset block
   always #10 clock = ~clock;

   // reference data
   logic [3:0] rom_ref [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // game-level model: 0 idle, 1 playing, 2 won, 3 lost
   int         m_mode = 0;
   int         m_pos  = 0;
   logic [3:0] m_last = 4'd0;

   // scoreboard: expected {acertou, errou, pronto} after each play
   logic [2:0] exp_q[$];

   function automatic logic [6:0] exp_hex(input logic [3:0] v);
`ifdef DB_HEX_EN
      return seg_tab[v];
`else
      return 7'h7F;
`endif
   endfunction

   function automatic logic [3:0] mode_code();
      case (m_mode)
         1: return 4'h2;
         2: return 4'hA;
         3: return 4'hE;
         default: return 4'h0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, ".acertou"}, 32'(acertou), 32'(m_mode == 2));
      check({tag, ".errou"},   32'(errou),   32'(m_mode == 3));
      check({tag, ".pronto"},  32'(pronto),  32'(m_mode >= 2));
   endtask

   task automatic check_dbg(input string tag);
      check({tag, ".db_estado"},      32'(db_estado),      32'(exp_hex(mode_code())));
      check({tag, ".db_contagem"},    32'(db_contagem),    32'(exp_hex(4'(m_pos))));
      check({tag, ".db_memoria"},     32'(db_memoria),     32'(exp_hex(rom_ref[m_pos])));
      check({tag, ".db_jogadafeita"}, 32'(db_jogadafeita), 32'(exp_hex(m_last)));
   endtask

   // driver tasks
   task automatic do_reset(input string tag);
      @(posedge clock); #1;
      chaves = 4'd0;
      reset  = 1'b1;
      m_mode = 0; m_pos = 0; m_last = 4'd0;
      #1;
      check_flags({tag, ".async"});
      check_dbg({tag, ".async"});
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic do_start(input int cycles);
      @(posedge clock); #1;
      iniciar = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (i == 0) check("db_iniciar", 32'(db_iniciar), 32'd1);
      end
      @(posedge clock); #1;
      iniciar = 1'b0;
      if (m_mode != 1) begin
         m_mode = 1; m_pos = 0; m_last = 4'd0;
      end
      @(negedge clock); @(negedge clock);
      check_flags("start");
      check_dbg("start");
   endtask

   task automatic do_play(input logic [3:0] v, input int hold);
      int   extra;
      logic was_playing;
      @(posedge clock); #1;
      chaves = v;
      @(negedge clock);
      check("tem_jogada_rise", 32'(db_tem_jogada), 32'd1);
      check("leds", 32'(leds), 32'(v));
      was_playing = (m_mode == 1);
      extra = 0;
      for (int i = 1; i < hold; i++) begin
         @(negedge clock);
         if (db_tem_jogada) extra++;
         if (i == 2 && was_playing)
            check("db_igual", 32'(db_igual), 32'(v == rom_ref[m_pos]));
      end
      check("single_pulse", 32'(extra), 32'd0);
      @(posedge clock); #1;
      chaves = 4'd0;
      if (was_playing) begin
         m_last = v;
         if (v != rom_ref[m_pos])  m_mode = 3;
         else if (m_pos == 15)     m_mode = 2;
         else                      m_pos++;
      end
      exp_q.push_back({m_mode == 2, m_mode == 3, m_mode >= 2});
      @(negedge clock); @(negedge clock);
      check("flags", 32'({acertou, errou, pronto}), 32'(exp_q.pop_front()));
      check_dbg("play");
   endtask

   function automatic logic [3:0] wrong_play(input int k);
      logic [3:0] v;
      do v = 4'($urandom_range(1, 15)); while (v == rom_ref[k]);
      return v;
   endfunction

   initial begin
      // reset state
      do_reset("reset0");
      repeat (10) @(posedge clock);
      @(negedge clock);
      check_flags("idle");
      check_dbg("idle");
      check("db_clock_low", 32'(db_clock), 32'd0);

      // a play while idle is ignored
      do_play(4'h1, 3);

      // directed game: four correct plays then a wrong fifth
      do_start(5);
      do_play(4'h1, 10);
      do_play(4'h2, 4);
      do_play(4'h4, 4);
      do_play(4'h8, 4);
      do_play(4'h1, 5);
      check("lost_pos", 32'(m_pos), 32'd4);
      do_play(4'h4, 3);

      // full winning game, then restart and reset mid-game
      do_start(2);
      for (int k = 0; k < 16; k++) do_play(rom_ref[k], 3);
      do_play(4'h2, 3);
      do_start(3);
      do_play(4'h1, 3);
      do_play(4'h2, 3);
      do_start(2);
      do_play(4'h4, 3);
      do_reset("reset_mid");
      @(negedge clock);
      check_flags("after_reset");
      check_dbg("after_reset");

      // randomized games
      for (int g = 0; g < 20; g++) begin
         int err_at, rst_at;
         do_start($urandom_range(1, 4));
         err_at = $urandom_range(0, 23);
         rst_at = (g % 4 == 3) ? $urandom_range(1, 15) : 99;
         for (int k = 0; k < 16; k++) begin
            if (m_mode != 1) break;
            if (k == rst_at) begin
               do_reset("reset_rand");
               break;
            end
            do_play((k == err_at) ? wrong_play(k) : rom_ref[k], $urandom_range(3, 8));
            repeat ($urandom_range(0, 3)) @(posedge clock);
         end
         if (m_mode >= 2) do_play(4'($urandom_range(1, 15)), 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
